// File: rtl/arith_pipe.sv
// arith_pipe: pipelined RV32I/RV64I integer ALU with valid/ready handshakes.
//
// Purpose:
//   Evaluates ADD/SUB/SLL/SLT/SLTU/XOR/SRL/SRA/OR/AND from the accepted inputs,
//   registers the result into stage 1, then delays it through STAGES-1 more
//   register stages. A sideband tag travels with each operation.
//
// Optional feature (macro ARITH_PIPE_MUL_EN):
//   When defined, mext=1 selects MUL/MULH/MULHSU/MULHU for funct3 000..011
//   and returns all-ones for the divide group (funct3 1xx). When undefined,
//   no multiplier is built and mext is ignored.
//
// Ports:
//   clk       in   clock, rising edge
//   resetn    in   synchronous active-high reset
//   in_valid  in   operation present
//   in_ready  out  operation can be accepted this cycle
//   funct3    in   operation select
//   alt       in   funct7[5]: SUB / SRA select
//   mext      in   funct7[0]: M-extension group select
//   x, y      in   operands
//   tag_in    in   sideband tag
//   out_valid out  result valid
//   out_ready in   consumer takes result this cycle
//   result    out  computed result
//   tag_out   out  tag belonging to result

module arith_pipe #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned STAGES = 1,
    parameter int unsigned TAG_W  = 5
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       funct3,
    input  logic             alt,
    input  logic             mext,
    input  logic [XLEN-1:0]  x,
    input  logic [XLEN-1:0]  y,
    input  logic [TAG_W-1:0] tag_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  result,
    output logic [TAG_W-1:0] tag_out
);

    localparam int unsigned SHW = $clog2(XLEN);

    logic [SHW-1:0]  w_shamt;
    logic [XLEN-1:0] w_alu;
    logic [XLEN-1:0] w_res;
    logic            w_stall;

    logic [STAGES-1:0] r_valid;
    logic [XLEN-1:0]   r_res [STAGES];
    logic [TAG_W-1:0]  r_tag [STAGES];

    assign w_shamt = y[SHW-1:0];

    always_comb begin
        w_alu = '0;
        case (funct3)
            3'b000:  w_alu = alt ? (x - y) : (x + y);
            3'b001:  w_alu = x << w_shamt;
            3'b010:  w_alu = {{(XLEN-1){1'b0}}, ($signed(x) < $signed(y))};
            3'b011:  w_alu = {{(XLEN-1){1'b0}}, (x < y)};
            3'b100:  w_alu = x ^ y;
            3'b101:  w_alu = alt ? XLEN'($signed(x) >>> w_shamt) : (x >> w_shamt);
            3'b110:  w_alu = x | y;
            default: w_alu = x & y;
        endcase
    end

`ifdef ARITH_PIPE_MUL_EN
    // One extra bit per operand lets a single signed multiplier cover all
    // three signedness combinations: the extension bit is the sign or zero.
    logic              w_x_signed;
    logic              w_y_signed;
    logic [XLEN:0]     w_xe;
    logic [XLEN:0]     w_ye;
    logic [2*XLEN+1:0] w_prod;
    logic [1:0]        w_unused_prod;
    logic [XLEN-1:0]   w_mul;

    assign w_x_signed    = (funct3 == 3'b001) || (funct3 == 3'b010);
    assign w_y_signed    = (funct3 == 3'b001);
    assign w_xe          = {w_x_signed & x[XLEN-1], x};
    assign w_ye          = {w_y_signed & y[XLEN-1], y};
    assign w_prod        = $signed(w_xe) * $signed(w_ye);
    assign w_unused_prod = w_prod[2*XLEN+1:2*XLEN];

    always_comb begin
        w_mul = '1;
        case (funct3)
            3'b000:                 w_mul = w_prod[XLEN-1:0];
            3'b001, 3'b010, 3'b011: w_mul = w_prod[2*XLEN-1:XLEN];
            default:                w_mul = '1;
        endcase
    end

    always_comb begin
        w_res = w_alu;
        if (mext) begin
            w_res = w_mul;
        end
    end
`else
    logic w_unused_mext;
    assign w_unused_mext = mext;

    always_comb begin
        w_res = w_alu;
    end
`endif

    // A stalled output freezes the whole pipe, so data never overtakes.
    assign w_stall   = out_valid && !out_ready;
    assign in_ready  = !w_stall;
    assign out_valid = r_valid[STAGES-1];
    assign result    = r_res[STAGES-1];
    assign tag_out   = r_tag[STAGES-1];

    always_ff @(posedge clk) begin
        if (resetn) begin
            r_valid <= '0;
            for (int i = 0; i < STAGES; i++) begin
                r_res[i] <= '0;
                r_tag[i] <= '0;
            end
        end else if (!w_stall) begin
            r_valid[0] <= in_valid;
            if (in_valid) begin
                r_res[0] <= w_res;
                r_tag[0] <= tag_in;
            end
            for (int i = 1; i < STAGES; i++) begin
                r_valid[i] <= r_valid[i-1];
                r_res[i]   <= r_res[i-1];
                r_tag[i]   <= r_tag[i-1];
            end
        end
    end

endmodule

// File: doc/arith_pipe.md
Name: arith_pipe

Overview:
- Parametrised successor to the single-stage integer ALU in the candy core.
- Covers the full RV32I/RV64I register-register and register-immediate operation set: ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND.
- Configurable datapath width and pipeline depth, with valid/ready handshakes on both sides and a tag carried alongside each operation.
- Sits between decode/register-fetch and writeback; accepts one operation per cycle when not stalled.

Parameters:
- XLEN, 32, datapath width in bits; legal values 32 or 64.
- STAGES, 1, number of register stages from accept to result; legal range 1..4.
- TAG_W, 5, width of the sideband tag (destination register index by default).

Ports:
- clk  input  1  clock; all state changes on its rising edge.
- resetn  input  1  synchronous, active-high reset; the block is reset when resetn is 1 at a rising clk edge.
- in_valid  input  1  operation present on the input fields.
- in_ready  output  1  block can accept an operation this cycle.
- funct3  input  3  RISC-V funct3 operation select.
- alt  input  1  funct7[5]: selects SUB instead of ADD, SRA instead of SRL.
- mext  input  1  funct7[0]: selects the M-extension group (see Optional Feature).
- x  input  XLEN  left operand (rs1 or pc).
- y  input  XLEN  right operand (rs2 or immediate).
- tag_in  input  TAG_W  sideband tag, passed through unchanged.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result this cycle.
- result  output  XLEN  computed result.
- tag_out  output  TAG_W  tag belonging to result.

Behaviour:
- Reset:
  - All stage valid bits clear, so out_valid=0.
  - result=0, tag_out=0.
  - in_ready=1 in the first cycle after reset.
- Reset mid-operation discards all in-flight operations; nothing is emitted for them.
- Handshake:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
  - Once out_valid is 1, result and tag_out stay stable until the output transfer completes.
- Stall:
  - stall = out_valid && !out_ready.
  - in_ready = !stall.
  - While stalled, every stage holds its contents.
- Pipeline:
  - With no stall, an operation accepted in cycle N shows out_valid=1 in cycle N+STAGES.
  - Throughput is one operation per cycle.
  - Bubbles propagate as valid=0 stages.
  - The arithmetic is evaluated from the accepted inputs and registered into stage 1; stages 2..STAGES are pure delay.
  - Operation order is preserved.
- Operations (shamt = y[log2(XLEN)-1:0]; upper bits of y are ignored for shifts):
  - 000: alt=0 gives x+y; alt=1 gives x-y. Both wrap modulo 2^XLEN.
  - 001: x << shamt.
  - 010: SLT, result 1 if $signed(x) < $signed(y), else 0; zero-extended to XLEN.
  - 011: SLTU, unsigned compare; result 1 or 0, zero-extended to XLEN.
  - 100: x ^ y.
  - 101: alt=0 gives logical x >> shamt; alt=1 gives arithmetic shift, sign-filled from x[XLEN-1].
  - 110: x | y.
  - 111: x & y.
  - alt is ignored for every funct3 other than 000 and 101.
- mext=1 with the feature compiled out: treated as mext=0.
- Simultaneous input and output transfer in the same cycle is legal and keeps full throughput.

Optional Feature:
- Macro: ARITH_PIPE_MUL_EN.
- Defined:
  - mext=1 with funct3 000/001/010/011 selects MUL / MULH / MULHSU / MULHU.
  - MUL returns the low XLEN bits of the 2*XLEN-bit product.
  - MULH* return the high XLEN bits, with RISC-V signedness (MULHSU: x signed, y unsigned).
  - mext=1 with funct3 1xx (divide ops) returns all-ones.
  - Timing, handshake and latency are unchanged: STAGES still applies.
- Undefined: no multiplier is instantiated; mext is ignored.

Test Plan:
- Reset, then x=5, y=3, funct3=000, alt=0, tag_in=7, STAGES=1 -> result=8 and tag_out=7 with out_valid one cycle after accept; result=0 and out_valid=0 immediately after reset.
- x=3, y=5, alt=1 (SUB) -> 0xFFFFFFFE. SLT x=0xFFFFFFFF, y=1 -> 1. SLTU with the same operands -> 0.
- SRA x=0x80000000, y=0x24 (shamt 4) -> 0xF8000000. SRL with the same operands -> 0x08000000. SLL x=1, y=31 -> 0x80000000.
- STAGES=3, back-to-back ADDs with tags 1..6, out_ready held 0 for cycles 4-7 -> in_ready=0 during the stall; all six results emerge in order with no loss or duplication; result is stable while stalled.
- Assert resetn with three operations in flight -> next cycle out_valid=0, and none of those three results is ever emitted.
- With ARITH_PIPE_MUL_EN: MULHU x=y=0xFFFFFFFF -> 0xFFFFFFFE; MULH x=y=0xFFFFFFFF -> 0; MUL -> 1. Without the macro: mext=1, funct3=000, x=2, y=3 -> 5.
